// File: rtl/e_tdmrc_pkg.sv
// Shared types and byte transforms for the TDMRC message generator.
// Optional self-check datapath: build with E_TDMRC_SELFCHECK_EN defined.
package e_tdmrc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PROC = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int ROT_AMT = 3;

    function automatic logic [7:0] rotl8(input logic [7:0] x);
        return (x << ROT_AMT) | (x >> (8 - ROT_AMT));
    endfunction

    function automatic logic [7:0] rotr8(input logic [7:0] x);
        return (x >> ROT_AMT) | (x << (8 - ROT_AMT));
    endfunction

    // c = rotl3(p ^ kb) + ad (mod 256)
    function automatic logic [7:0] enc_byte(input logic [7:0] p,
                                            input logic [7:0] kb,
                                            input logic [7:0] ad);
        logic [7:0] t;
        t = rotl8(p ^ kb);
        return t + ad;
    endfunction

    // p = rotr3(c - ad) ^ kb  (exact inverse of enc_byte)
    function automatic logic [7:0] dec_byte(input logic [7:0] c,
                                            input logic [7:0] kb,
                                            input logic [7:0] ad);
        logic [7:0] t;
        t = c - ad;
        return rotr8(t) ^ kb;
    endfunction

endpackage

// File: rtl/e_tdmrc_byte_core.sv
// Combinational single-byte transform: encrypt (i_mode=0) or decrypt (i_mode=1).
module e_tdmrc_byte_core
    import e_tdmrc_pkg::*;
(
    input  logic       i_mode,
    input  logic [7:0] i_kb,
    input  logic [7:0] i_ad,
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    // Select direction; both functions are pure logic.
    always_comb begin
        o_byte = i_mode ? dec_byte(i_byte, i_kb, i_ad) : enc_byte(i_byte, i_kb, i_ad);
    end

endmodule

// File: rtl/e_tdmrc_gen.sv
// TDMRC message generator: collects MSG_BYTES bytes, transforms one byte per
// cycle, and holds the result until the consumer accepts it.
// Optional self-check datapath: E_TDMRC_SELFCHECK_EN.
module e_tdmrc_gen
    import e_tdmrc_pkg::*;
#(
    parameter int MSG_BYTES = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            master_key,
    input  logic [15:0]            subkey,
    input  logic [15:0]            subkey1,
    input  logic [15:0]            subkey2,
    input  logic [15:0]            subkey3,
    input  logic                   mode,
    input  logic                   flush,
    input  logic [7:0]             data_in,
    input  logic                   data_valid,
    output logic                   data_ready,
    output logic [8*MSG_BYTES-1:0] out_flat,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic [8*MSG_BYTES-1:0] decrypted_text_flat,
    output logic                   check_ok
);

    localparam int         W        = 8 * MSG_BYTES;
    localparam logic [5:0] LAST_IDX = 6'(MSG_BYTES - 1);

    state_t         r_state;
    state_t         w_state_next;
    logic [5:0]     r_cnt;
    logic [1:0]     r_slot;
    logic [W-1:0]   r_buf;
    logic [W-1:0]   r_out;
    logic           r_mode;
    logic [31:0]    r_mkey;
    logic [15:0]    r_sk0, r_sk1, r_sk2, r_sk3;

    logic [15:0]    w_sk;
    logic [7:0]     w_mkb;
    logic [7:0]     w_kb;
    logic [7:0]     w_ad;
    logic [7:0]     w_in_byte;
    logic [7:0]     w_res;
    logic [W-1:0]   w_din_ext;
    logic [W-1:0]   w_res_ext;

    // Bytes are shifted in at the LSB end so byte 0 ends up in the MSBs.
    assign w_in_byte = r_buf[W-1 -: 8];
    assign out_flat  = r_out;

    // Zero-extend single bytes to message width for the shift registers.
    always_comb begin
        w_din_ext      = '0;
        w_din_ext[7:0] = data_in;
        w_res_ext      = '0;
        w_res_ext[7:0] = w_res;
    end

    // Key slot s = j mod 4 picks subkey S_s and master key byte s.
    always_comb begin
        w_sk  = r_sk0;
        w_mkb = r_mkey[7:0];
        case (r_slot)
            2'd0: begin w_sk = r_sk0; w_mkb = r_mkey[7:0];   end
            2'd1: begin w_sk = r_sk1; w_mkb = r_mkey[15:8];  end
            2'd2: begin w_sk = r_sk2; w_mkb = r_mkey[23:16]; end
            default: begin w_sk = r_sk3; w_mkb = r_mkey[31:24]; end
        endcase
        w_kb = w_sk[7:0] ^ w_mkb;
        w_ad = w_sk[15:8];
    end

    e_tdmrc_byte_core u_core (
        .i_mode (r_mode),
        .i_kb   (w_kb),
        .i_ad   (w_ad),
        .i_byte (w_in_byte),
        .o_byte (w_res)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state and handshake outputs; flush overrides every transition.
    always_comb begin
        w_state_next = r_state;
        data_ready   = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b1;
        case (r_state)
            ST_IDLE: begin
                data_ready = 1'b1;
                busy       = 1'b0;
                if (data_valid)
                    w_state_next = (r_cnt == LAST_IDX) ? ST_PROC : ST_LOAD;
            end
            ST_LOAD: begin
                data_ready = 1'b1;
                if (data_valid && r_cnt == LAST_IDX)
                    w_state_next = ST_PROC;
            end
            ST_PROC: begin
                if (r_cnt == LAST_IDX)
                    w_state_next = ST_DONE;
            end
            default: begin
                out_valid = 1'b1;
                if (out_ready)
                    w_state_next = ST_IDLE;
            end
        endcase
        if (flush)
            w_state_next = ST_IDLE;
    end

    // Byte capture, key latching and per-byte processing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_slot <= '0;
            r_buf  <= '0;
            r_out  <= '0;
            r_mode <= 1'b0;
            r_mkey <= '0;
            r_sk0  <= '0;
            r_sk1  <= '0;
            r_sk2  <= '0;
            r_sk3  <= '0;
        end else if (flush) begin
            r_cnt  <= '0;
            r_slot <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_LOAD: begin
                    if (data_valid) begin
                        r_buf  <= (r_buf << 8) | w_din_ext;
                        r_cnt  <= (r_cnt == LAST_IDX) ? 6'd0 : r_cnt + 6'd1;
                        r_slot <= '0;
                        if (r_state == ST_IDLE) begin
                            r_mode <= mode;
                            r_mkey <= master_key;
                            r_sk0  <= subkey;
                            r_sk1  <= subkey1;
                            r_sk2  <= subkey2;
                            r_sk3  <= subkey3;
                        end
                    end
                end
                ST_PROC: begin
                    r_out  <= (r_out << 8) | w_res_ext;
                    r_buf  <= r_buf << 8;
                    r_cnt  <= (r_cnt == LAST_IDX) ? 6'd0 : r_cnt + 6'd1;
                    r_slot <= r_slot + 2'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef E_TDMRC_SELFCHECK_EN
    logic [W-1:0] r_dec;
    logic         r_match;
    logic [7:0]   w_chk;
    logic [7:0]   w_dec_byte;
    logic [W-1:0] w_dec_ext;

    // Round-trip the produced byte back through an inverse transform.
    e_tdmrc_byte_core u_chk_core (
        .i_mode (1'b1),
        .i_kb   (w_kb),
        .i_ad   (w_ad),
        .i_byte (w_res),
        .o_byte (w_chk)
    );

    // In decrypt mode the produced byte already is the plaintext.
    always_comb begin
        w_dec_byte     = r_mode ? w_res : w_chk;
        w_dec_ext      = '0;
        w_dec_ext[7:0] = w_dec_byte;
    end

    // Accumulate recovered plaintext and the running match flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dec   <= '0;
            r_match <= 1'b0;
        end else if (!flush) begin
            if (r_state == ST_IDLE && data_valid)
                r_match <= 1'b1;
            else if (r_state == ST_PROC) begin
                r_dec   <= (r_dec << 8) | w_dec_ext;
                r_match <= r_match & (r_mode | (w_chk == w_in_byte));
            end
        end
    end

    assign decrypted_text_flat = r_dec;
    assign check_ok            = (r_state == ST_DONE) && r_match;
`else
    assign decrypted_text_flat = '0;
    assign check_ok            = 1'b0;
`endif

endmodule

// File: tb/tb_e_tdmrc_gen.sv
module tb_e_tdmrc_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] master_key = '0;
    logic [15:0] subkey = '0, subkey1 = '0, subkey2 = '0, subkey3 = '0;
    logic        mode = 1'b0;
    logic        flush = 1'b0;
    logic [7:0]  data_in = '0;
    logic        data_valid = 1'b0;
    logic        data_ready;
    logic [39:0] out_flat;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        busy;
    logic [39:0] decrypted_text_flat;
    logic        check_ok;

    int checks = 0;
    int failures = 0;

`ifdef E_TDMRC_SELFCHECK_EN
    localparam bit SC = 1'b1;
`else
    localparam bit SC = 1'b0;
`endif

    e_tdmrc_gen #(.MSG_BYTES(5)) dut (
        .clk(clk), .rst(rst), .master_key(master_key),
        .subkey(subkey), .subkey1(subkey1), .subkey2(subkey2), .subkey3(subkey3),
        .mode(mode), .flush(flush), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .out_flat(out_flat), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy),
        .decrypted_text_flat(decrypted_text_flat), .check_ok(check_ok)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mode;
        logic [39:0] din;
        logic [39:0] dout;
        int          hold;
    } vec_t;

    vec_t vecs[5];
    logic [39:0] last_out;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic set_keys(input bit good);
        if (good) begin
            master_key = 32'h009a4e2a; subkey = 16'h04d2; subkey1 = 16'h162e;
            subkey2 = 16'h03eb; subkey3 = 16'h0647;
        end else begin
            master_key = 32'h13579bdf; subkey = 16'hffff; subkey1 = 16'h1234;
            subkey2 = 16'h5555; subkey3 = 16'haaaa;
        end
    endtask

    // Drive a message; gap inserts an idle cycle between bytes, keychg
    // scrambles keys and mode after byte 0. Returns edges until out_valid.
    task automatic send_msg(input logic [39:0] msg, input logic m, input bit gap,
                            input bit keychg, output int lat);
        bit ready_bad;
        ready_bad = 1'b0;
        set_keys(1'b1);
        mode = m;
        for (int i = 0; i < 5; i++) begin
            if (gap && i > 0) begin
                data_valid = 1'b0;
                data_in    = 8'h5a;
                @(posedge clk); #1;
            end
            data_in    = msg[39-8*i -: 8];
            data_valid = 1'b1;
            @(posedge clk); #1;
            if (keychg && i == 0) begin
                set_keys(1'b0);
                mode = ~m;
            end
        end
        data_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            if (data_ready) ready_bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        chk("proc_ready_low", {63'd0, ready_bad}, 64'd0);
        set_keys(1'b1);
        mode = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic m, input logic [39:0] din,
                                input logic [39:0] exp, input int lat);
        chk({tag, "_latency"}, lat, 5);
        chk({tag, "_out_flat"}, out_flat, exp);
        chk({tag, "_out_valid"}, out_valid, 1);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_check_ok"}, check_ok, SC);
        chk({tag, "_decrypted"}, decrypted_text_flat, SC ? (m ? exp : din) : 40'd0);
    endtask

    task automatic accept;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("accept_idle_busy", busy, 0);
        chk("accept_out_valid", out_valid, 0);
        chk("accept_data_ready", data_ready, 1);
    endtask

    initial begin
        int lat;
        vecs[0] = '{mode: 1'b0, din: 40'h46494d4a44, dout: 40'hf95fe46ee9, hold: 0};
        vecs[1] = '{mode: 1'b1, din: 40'hf95fe46ee9, dout: 40'h46494d4a44, hold: 0};
        vecs[2] = '{mode: 1'b0, din: 40'h0000000000, dout: 40'hcb198e40cb, hold: 10};
        vecs[3] = '{mode: 1'b0, din: 40'hffffffffff, dout: 40'h3c1277cb3c, hold: 2};
        vecs[4] = '{mode: 1'b1, din: 40'hcb198e40cb, dout: 40'h0000000000, hold: 0};

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_out_flat", out_flat, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_check_ok", check_ok, 0);
        chk("rst_decrypted", decrypted_text_flat, 0);
        chk("rst_data_ready", data_ready, 1);

        // Table-driven messages, with optional hold while out_ready=0
        for (int v = 0; v < 5; v++) begin
            send_msg(vecs[v].din, vecs[v].mode, 1'b0, 1'b0, lat);
            $display("vec %0d mode=%0d in=%h out=%h lat=%0d", v, vecs[v].mode,
                     vecs[v].din, out_flat, lat);
            check_result("vec", vecs[v].mode, vecs[v].din, vecs[v].dout, lat);
            for (int h = 0; h < vecs[v].hold; h++) begin
                data_valid = 1'b1;       // must be ignored in DONE
                data_in    = 8'h77;
                @(posedge clk); #1;
                chk("hold_out_flat", out_flat, vecs[v].dout);
                chk("hold_out_valid", out_valid, 1);
                chk("hold_data_ready", data_ready, 0);
                chk("hold_check_ok", check_ok, SC);
                chk("hold_decrypted", decrypted_text_flat,
                    SC ? (vecs[v].mode ? vecs[v].dout : vecs[v].din) : 40'd0);
            end
            data_valid = 1'b0;
            accept();
            last_out = vecs[v].dout;
        end

        // Flush after 3 bytes, with a simultaneous byte offered
        set_keys(1'b1);
        mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data_in = 8'h11 * 8'(i + 1); data_valid = 1'b1;
            @(posedge clk); #1;
        end
        flush = 1'b1; data_in = 8'haa;
        @(posedge clk); #1;
        flush = 1'b0; data_valid = 1'b0;
        $display("flush after 3 bytes busy=%0d out=%h", busy, out_flat);
        chk("flush_busy", busy, 0);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_out_retained", out_flat, last_out);
        send_msg(40'h46494d4a44, 1'b0, 1'b0, 1'b0, lat);
        $display("post-flush msg out=%h lat=%0d", out_flat, lat);
        check_result("post_flush", 1'b0, 40'h46494d4a44, 40'hf95fe46ee9, lat);

        // Flush in DONE beats a simultaneous out_ready
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; out_ready = 1'b0;
        $display("flush in DONE out_valid=%0d out=%h", out_valid, out_flat);
        chk("done_flush_out_valid", out_valid, 0);
        chk("done_flush_busy", busy, 0);
        chk("done_flush_out_retained", out_flat, 40'hf95fe46ee9);

        // Reset during PROC discards everything
        send_msg(40'h0000000000, 1'b0, 1'b0, 1'b0, lat);
        accept();
        for (int i = 0; i < 5; i++) begin
            data_in = 8'h46 + 8'(i); data_valid = 1'b1;
            @(posedge clk); #1;
        end
        data_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        $display("async rst in PROC out=%h busy=%0d", out_flat, busy);
        chk("prst_out_flat", out_flat, 0);
        chk("prst_out_valid", out_valid, 0);
        chk("prst_busy", busy, 0);
        chk("prst_check_ok", check_ok, 0);
        chk("prst_decrypted", decrypted_text_flat, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("prst_data_ready", data_ready, 1);
        send_msg(40'h46494d4a44, 1'b0, 1'b0, 1'b0, lat);
        $display("post-reset msg out=%h lat=%0d", out_flat, lat);
        check_result("post_rst", 1'b0, 40'h46494d4a44, 40'hf95fe46ee9, lat);
        accept();

        // data_valid toggling 1-0-1 and key/mode change after byte 0
        send_msg(40'h46494d4a44, 1'b0, 1'b1, 1'b1, lat);
        $display("gapped msg with key change out=%h lat=%0d", out_flat, lat);
        check_result("gap_keychg", 1'b0, 40'h46494d4a44, 40'hf95fe46ee9, lat);
        accept();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

endmodule
